caravel_reset_sequencer: RTL and testbench

- Sequences staged release of NUM_DOMAINS downstream reset domains (e.g. management core, housekeeping, user project, peripherals) after power-on and after any later reset request.
- Arbitrates four reset sources: POR, SPI ext_reset, software request and optional watchdog.
- Sits after the synchronized POR reset, in the ext_clk domain. Drives active-low per-domain resets plus a status/cause register.

---
 rtl/caravel_reset_sequencer_if.sv | 26 ++
 rtl/caravel_reset_sequencer.sv | 102 ++++++++++
 tb/tb_caravel_reset_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/caravel_reset_sequencer_if.sv
// caravel_reset_sequencer_if: reset request and status bundle between a reset controller and the sequencer
// master: drives ext_reset, sw_rst_req, sw_rst_mask, wdt_en, wdt_kick, wdt_load; observes domain_rstn, seq_busy, rst_cause, wdt_timeout
// slave : the sequencer side, opposite directions
interface caravel_reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int WDT_W = 16
);
  logic ext_reset;
  logic sw_rst_req;
  logic [NUM_DOMAINS-1:0] sw_rst_mask;
  logic wdt_en;
  logic wdt_kick;
  logic [WDT_W-1:0] wdt_load;
  logic [NUM_DOMAINS-1:0] domain_rstn;
  logic seq_busy;
  logic [1:0] rst_cause;
  logic wdt_timeout;
  modport master (
    output ext_reset, sw_rst_req, sw_rst_mask, wdt_en, wdt_kick, wdt_load,
    input domain_rstn, seq_busy, rst_cause, wdt_timeout
  );
  modport slave (
    input ext_reset, sw_rst_req, sw_rst_mask, wdt_en, wdt_kick, wdt_load,
    output domain_rstn, seq_busy, rst_cause, wdt_timeout
  );
endinterface

// File: rtl/caravel_reset_sequencer.sv
// caravel_reset_sequencer: staged release of per-domain active-low resets with POR/EXT/SW/WDT cause tracking
// ext_clk, reset : clock and synchronous active-high reset (synchronized POR)
// sif (slave)    : trigger inputs, watchdog controls, domain_rstn/seq_busy/rst_cause/wdt_timeout outputs
// Optional watchdog built only when CARAVEL_RST_WDT_EN is defined.
module caravel_reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_GAP = 4,
  parameter int WDT_W = 16
) (
  input logic ext_clk,
  input logic reset,
  caravel_reset_sequencer_if.slave sif
);
  localparam int CMAX = HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  typedef enum logic [1:0] {HOLD, STAGE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [NUM_DOMAINS-1:0] mask, mask_n, rstn_q, rstn_n;
  logic [1:0] cause, cause_n;
  logic wdt_to, wdt_to_n, wdt_fire;
`ifdef CARAVEL_RST_WDT_EN
  logic [WDT_W-1:0] wdt_cnt;
  logic wdt_en_q, wdt_reload;
  // a kick (or enable edge) on the expiry edge reloads instead of firing
  assign wdt_reload = sif.wdt_kick || (sif.wdt_en && !wdt_en_q);
  assign wdt_fire = state == RUN && sif.wdt_en && wdt_cnt == '0 && !wdt_reload;
  always_ff @(posedge ext_clk)
    if (reset) begin
      wdt_cnt <= '0;
      wdt_en_q <= 1'b0;
    end else begin
      wdt_en_q <= sif.wdt_en;
      if (wdt_reload || wdt_fire) wdt_cnt <= sif.wdt_load;
      else if (state == RUN && sif.wdt_en) wdt_cnt <= wdt_cnt - WDT_W'(1);
    end
`else
  logic [WDT_W+1:0] unused_wdt;
  assign unused_wdt = {sif.wdt_en, sif.wdt_kick, sif.wdt_load};
  assign wdt_fire = 1'b0;
`endif
  always_ff @(posedge ext_clk)
    if (reset) begin
      state <= HOLD;
      cnt <= '0;
      idx <= '0;
      mask <= '1;
      rstn_q <= '0;
      cause <= 2'd0;
      wdt_to <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      mask <= mask_n;
      rstn_q <= rstn_n;
      cause <= cause_n;
      wdt_to <= wdt_to_n;
    end
  // trigger edges zero the counter; the first trigger-free edge counts as 1,
  // so domain k releases HOLD_CYCLES + k*STAGE_GAP edges after it
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    mask_n = mask;
    rstn_n = rstn_q;
    cause_n = cause;
    wdt_to_n = wdt_fire && !sif.ext_reset;
    if (sif.ext_reset || wdt_fire) begin
      state_n = HOLD;
      cnt_n = '0;
      idx_n = '0;
      mask_n = '1;
      rstn_n = '0;
      cause_n = sif.ext_reset ? 2'd1 : 2'd3;
    end else if (sif.sw_rst_req && state == RUN) begin
      state_n = HOLD;
      cnt_n = '0;
      idx_n = '0;
      mask_n = sif.sw_rst_mask;
      rstn_n = rstn_q & ~sif.sw_rst_mask;
      cause_n = 2'd2;
    end else if (state != RUN) begin
      if (cnt == (state == HOLD ? CW'(HOLD_CYCLES) : CW'(STAGE_GAP))) begin
        rstn_n[idx] = rstn_q[idx] | mask[idx];
        cnt_n = CW'(1);
        idx_n = idx + IW'(1);
        state_n = idx == IW'(NUM_DOMAINS - 1) ? RUN : STAGE;
      end else cnt_n = cnt + CW'(1);
    end
  end
  always_comb begin
    sif.domain_rstn = rstn_q;
    sif.seq_busy = state != RUN;
    sif.rst_cause = cause;
    sif.wdt_timeout = wdt_to;
  end
endmodule

// File: tb/tb_caravel_reset_sequencer.sv
// tb_caravel_reset_sequencer: directed self-checking bench for caravel_reset_sequencer
module tb_caravel_reset_sequencer;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  caravel_reset_sequencer_if #(.NUM_DOMAINS(4), .WDT_W(16)) sif ();
  caravel_reset_sequencer #(.NUM_DOMAINS(4), .HOLD_CYCLES(8), .STAGE_GAP(4), .WDT_W(16)) dut (
    .ext_clk(clk),
    .reset(reset),
    .sif(sif.slave)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // expected rstn k edges after the first trigger-free edge (k = 0 is that edge)
  function automatic logic [3:0] exp_rstn(int k, logic [3:0] m);
    logic [3:0] r;
    r = ~m;
    for (int d = 0; d < 4; d++) if (k >= 8 + 4 * d) r[d] = 1'b1;
    return r;
  endfunction
  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++; if (sif.domain_rstn !== 4'b0000) begin failures++; $display("FAIL reset_rstn got=%b exp=0000", sif.domain_rstn); end
    checks++; if (sif.seq_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", sif.seq_busy); end
    checks++; if (sif.rst_cause !== 2'd0) begin failures++; $display("FAIL reset_cause got=%0d exp=0", sif.rst_cause); end
    checks++; if (sif.wdt_timeout !== 1'b0) begin failures++; $display("FAIL reset_wdt_timeout got=%b exp=0", sif.wdt_timeout); end
  endtask
  task automatic test_por;
    reset = 1'b0;
    for (int k = 0; k < 22; k++) begin
      tick;
      checks++; if (sif.domain_rstn !== exp_rstn(k, 4'b1111)) begin failures++; $display("FAIL por_rstn k=%0d got=%b exp=%b", k, sif.domain_rstn, exp_rstn(k, 4'b1111)); end
      checks++; if (sif.seq_busy !== (k < 20)) begin failures++; $display("FAIL por_busy k=%0d got=%b exp=%b", k, sif.seq_busy, k < 20); end
    end
    checks++; if (sif.rst_cause !== 2'd0) begin failures++; $display("FAIL por_cause got=%0d exp=0", sif.rst_cause); end
  endtask
  task automatic test_ext_reset;
    sif.ext_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (sif.domain_rstn !== 4'b0000) begin failures++; $display("FAIL ext_hold_rstn i=%0d got=%b exp=0000", i, sif.domain_rstn); end
    end
    sif.ext_reset = 1'b0;
    for (int k = 0; k < 22; k++) begin
      tick;
      checks++; if (sif.domain_rstn !== exp_rstn(k, 4'b1111)) begin failures++; $display("FAIL ext_rstn k=%0d got=%b exp=%b", k, sif.domain_rstn, exp_rstn(k, 4'b1111)); end
    end
    checks++; if (sif.rst_cause !== 2'd1) begin failures++; $display("FAIL ext_cause got=%0d exp=1", sif.rst_cause); end
  endtask
  task automatic test_sw_mask;
    sif.sw_rst_req = 1'b1;
    sif.sw_rst_mask = 4'b1010;
    tick;
    sif.sw_rst_req = 1'b0;
    checks++; if (sif.domain_rstn !== 4'b0101) begin failures++; $display("FAIL sw_assert_rstn got=%b exp=0101", sif.domain_rstn); end
    checks++; if (sif.rst_cause !== 2'd2) begin failures++; $display("FAIL sw_cause got=%0d exp=2", sif.rst_cause); end
    for (int k = 0; k < 22; k++) begin
      tick;
      checks++; if (sif.domain_rstn !== exp_rstn(k, 4'b1010)) begin failures++; $display("FAIL sw_rstn k=%0d got=%b exp=%b", k, sif.domain_rstn, exp_rstn(k, 4'b1010)); end
      checks++; if (sif.seq_busy !== (k < 20)) begin failures++; $display("FAIL sw_busy k=%0d got=%b exp=%b", k, sif.seq_busy, k < 20); end
    end
  endtask
  task automatic test_sw_zero_mask;
    sif.sw_rst_req = 1'b1;
    sif.sw_rst_mask = 4'b0000;
    tick;
    sif.sw_rst_req = 1'b0;
    checks++; if (sif.rst_cause !== 2'd2) begin failures++; $display("FAIL sw0_cause got=%0d exp=2", sif.rst_cause); end
    checks++; if (sif.seq_busy !== 1'b1) begin failures++; $display("FAIL sw0_busy_start got=%b exp=1", sif.seq_busy); end
    for (int k = 0; k < 22; k++) begin
      tick;
      checks++; if (sif.domain_rstn !== 4'b1111) begin failures++; $display("FAIL sw0_rstn k=%0d got=%b exp=1111", k, sif.domain_rstn); end
      checks++; if (sif.seq_busy !== (k < 20)) begin failures++; $display("FAIL sw0_busy k=%0d got=%b exp=%b", k, sif.seq_busy, k < 20); end
    end
  endtask
  task automatic test_sw_during_seq;
    sif.ext_reset = 1'b1;
    tick;
    sif.ext_reset = 1'b0;
    for (int k = 0; k < 22; k++) begin
      sif.sw_rst_req = (k == 3 || k == 15);
      sif.sw_rst_mask = 4'b1111;
      tick;
      sif.sw_rst_req = 1'b0;
      checks++; if (sif.domain_rstn !== exp_rstn(k, 4'b1111)) begin failures++; $display("FAIL swbusy_rstn k=%0d got=%b exp=%b", k, sif.domain_rstn, exp_rstn(k, 4'b1111)); end
    end
    checks++; if (sif.rst_cause !== 2'd1) begin failures++; $display("FAIL swbusy_cause got=%0d exp=1", sif.rst_cause); end
  endtask
  task automatic test_simultaneous;
    sif.ext_reset = 1'b1;
    sif.sw_rst_req = 1'b1;
    sif.sw_rst_mask = 4'b0001;
    tick;
    sif.ext_reset = 1'b0;
    sif.sw_rst_req = 1'b0;
    checks++; if (sif.domain_rstn !== 4'b0000) begin failures++; $display("FAIL simul_rstn got=%b exp=0000", sif.domain_rstn); end
    checks++; if (sif.rst_cause !== 2'd1) begin failures++; $display("FAIL simul_cause got=%0d exp=1", sif.rst_cause); end
    for (int k = 0; k < 22; k++) begin
      tick;
      checks++; if (sif.domain_rstn !== exp_rstn(k, 4'b1111)) begin failures++; $display("FAIL simul_seq_rstn k=%0d got=%b exp=%b", k, sif.domain_rstn, exp_rstn(k, 4'b1111)); end
    end
  endtask
  task automatic test_mid_seq_restart;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick;
      checks++; if (sif.domain_rstn !== exp_rstn(k, 4'b1111)) begin failures++; $display("FAIL mid_pre_rstn k=%0d got=%b exp=%b", k, sif.domain_rstn, exp_rstn(k, 4'b1111)); end
    end
    sif.ext_reset = 1'b1;
    tick;
    sif.ext_reset = 1'b0;
    checks++; if (sif.domain_rstn !== 4'b0000) begin failures++; $display("FAIL mid_reassert_rstn got=%b exp=0000", sif.domain_rstn); end
    checks++; if (sif.rst_cause !== 2'd1) begin failures++; $display("FAIL mid_cause got=%0d exp=1", sif.rst_cause); end
    for (int k = 0; k < 22; k++) begin
      tick;
      checks++; if (sif.domain_rstn !== exp_rstn(k, 4'b1111)) begin failures++; $display("FAIL mid_seq_rstn k=%0d got=%b exp=%b", k, sif.domain_rstn, exp_rstn(k, 4'b1111)); end
    end
  endtask
`ifdef CARAVEL_RST_WDT_EN
  task automatic test_wdt;
    sif.wdt_load = 16'd3;
    sif.wdt_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (sif.wdt_timeout !== 1'b0 || sif.domain_rstn !== 4'b1111) begin failures++; $display("FAIL wdt_pre i=%0d got=%b/%b exp=0/1111", i, sif.wdt_timeout, sif.domain_rstn); end
    end
    tick;
    checks++; if (sif.wdt_timeout !== 1'b1) begin failures++; $display("FAIL wdt_pulse got=%b exp=1", sif.wdt_timeout); end
    checks++; if (sif.domain_rstn !== 4'b0000) begin failures++; $display("FAIL wdt_rstn got=%b exp=0000", sif.domain_rstn); end
    checks++; if (sif.rst_cause !== 2'd3) begin failures++; $display("FAIL wdt_cause got=%0d exp=3", sif.rst_cause); end
    for (int k = 0; k < 22; k++) begin
      tick;
      checks++; if (sif.domain_rstn !== exp_rstn(k, 4'b1111) || sif.wdt_timeout !== 1'b0) begin failures++; $display("FAIL wdt_seq k=%0d got=%b/%b exp=%b/0", k, sif.domain_rstn, sif.wdt_timeout, exp_rstn(k, 4'b1111)); end
    end
    sif.wdt_en = 1'b0;
    sif.wdt_load = 16'd0;
    tick;
    sif.wdt_en = 1'b1;
    tick;
    sif.wdt_kick = 1'b1;
    tick;
    sif.wdt_kick = 1'b0;
    checks++; if (sif.wdt_timeout !== 1'b0) begin failures++; $display("FAIL wdt_kick_wins got=%b exp=0", sif.wdt_timeout); end
    tick;
    checks++; if (sif.wdt_timeout !== 1'b1) begin failures++; $display("FAIL wdt_load0_pulse got=%b exp=1", sif.wdt_timeout); end
    sif.wdt_en = 1'b0;
  endtask
`else
  task automatic test_wdt;
    sif.wdt_load = 16'd0;
    sif.wdt_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sif.wdt_kick = (i == 2);
      tick;
      checks++; if (sif.wdt_timeout !== 1'b0 || sif.domain_rstn !== 4'b1111 || sif.rst_cause === 2'd3) begin failures++; $display("FAIL nowdt i=%0d got=%b/%b/%0d exp=0/1111/not3", i, sif.wdt_timeout, sif.domain_rstn, sif.rst_cause); end
    end
    sif.wdt_kick = 1'b0;
    sif.wdt_en = 1'b0;
  endtask
`endif
  initial begin
    reset = 1'b1;
    sif.ext_reset = 1'b0;
    sif.sw_rst_req = 1'b0;
    sif.sw_rst_mask = 4'b0000;
    sif.wdt_en = 1'b0;
    sif.wdt_kick = 1'b0;
    sif.wdt_load = 16'd0;
    test_reset;
    test_por;
    test_ext_reset;
    test_sw_mask;
    test_sw_zero_mask;
    test_sw_during_seq;
    test_simultaneous;
    test_mid_seq_restart;
    test_wdt;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
